serpent_subkey_store: RTL and testbench

- Consumer end of the key-schedule subkey stream. Captures the 33 × 128-bit Serpent subkeys written as (subkey, address, valid) beats.
- Replays them to the round engine as a ready/valid stream: ascending for encryption (K0..K32), descending for decryption (K32..K0).
- Sits between key_schedule_slow and the XTS Serpent core, so one key expansion serves many blocks.

---
 rtl/serpent_pkg.sv | 11 +
 rtl/subkey_ram.sv | 20 ++
 rtl/serpent_subkey_store.sv | 108 ++++++++++
 tb/tb_serpent_subkey_store.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serpent_pkg.sv
// serpent_pkg: shared constants, state encoding and index stepping for the Serpent subkey store
package serpent_pkg;
  localparam int NUM_SUBKEYS = 33;
  localparam int SK_W = 128;
  localparam int ADDR_W = 6;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SUBKEYS - 1);
  typedef enum logic [2:0] {IDLE, LOADING, READY, STREAM, ZERO} state_e;
  function automatic logic [ADDR_W-1:0] step_idx(input logic [ADDR_W-1:0] i, input logic dec);
    return dec ? i - 1'b1 : i + 1'b1;
  endfunction
endpackage

// File: rtl/subkey_ram.sv
// subkey_ram: 33x128 single-write, single-read RAM with registered read port and no reset
module subkey_ram
  import serpent_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [SK_W-1:0]   i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [SK_W-1:0]   o_rdata
);
  logic [SK_W-1:0] mem_q [NUM_SUBKEYS];
  logic [SK_W-1:0] rd_q;
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) rd_q <= mem_q[i_raddr];
  end
  assign o_rdata = rd_q;
endmodule

// File: rtl/serpent_subkey_store.sv
// serpent_subkey_store: captures 33 Serpent subkeys and replays them ascending or descending.
// Define SUBKEY_STORE_ZEROIZE_EN to add the i_zeroize RAM sweep and o_zeroize_busy.
module serpent_subkey_store
  import serpent_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_begin,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [SK_W-1:0]   i_wr_subkey,
  input  logic              i_seq_start,
  input  logic              i_seq_decrypt,
  output logic              o_sk_valid,
  input  logic              i_sk_ready,
  output logic [SK_W-1:0]   o_sk_data,
  output logic [ADDR_W-1:0] o_sk_index,
  output logic              o_sk_last,
  output logic              o_keys_ready,
`ifdef SUBKEY_STORE_ZEROIZE_EN
  input  logic              i_zeroize,
  output logic              o_zeroize_busy,
`endif
  output logic              o_err
);
  state_e state_q, state_d;
  logic [NUM_SUBKEYS-1:0] bitmap_q, bitmap_d;
  logic err_q, err_d, dec_q, dec_d;
  logic [ADDR_W-1:0] idx_q, idx_d, zidx_q, step, rd_addr, wr_addr;
  logic zero_go, in_zero, load, wr_ok, wr_err, seq_ok, seq_err, hs, last, we, re;
  logic [SK_W-1:0] rd_data, wr_data;
`ifdef SUBKEY_STORE_ZEROIZE_EN
  assign zero_go = i_zeroize;
  assign in_zero = state_q == ZERO;
  assign o_zeroize_busy = in_zero;
  always_ff @(posedge i_clk) begin
    if (i_rst) zidx_q <= '0;
    else zidx_q <= zero_go ? '0 : in_zero ? zidx_q + 1'b1 : zidx_q;
  end
`else
  assign zero_go = 1'b0;
  assign in_zero = 1'b0;
  assign zidx_q = '0;
`endif
  assign load = i_load_begin && !in_zero;
  assign wr_ok = i_wr_valid && !load && !in_zero && state_q == LOADING && i_wr_addr <= LAST_IDX;
  assign wr_err = i_wr_valid && !load && !in_zero && !wr_ok;
  assign seq_ok = i_seq_start && !load && state_q == READY;
  assign seq_err = i_seq_start && !load && !in_zero && state_q != READY;
  assign hs = o_sk_valid && i_sk_ready;
  assign last = idx_q == (dec_q ? '0 : LAST_IDX);
  assign step = step_idx(idx_q, dec_q);
  // Prefetch the next entry on each handshake so beats arrive back to back
  assign rd_addr = seq_ok ? (i_seq_decrypt ? LAST_IDX : '0) : step;
  assign re = seq_ok || (hs && !last);
  assign we = wr_ok || in_zero;
  assign wr_addr = in_zero ? zidx_q : i_wr_addr;
  assign wr_data = in_zero ? '0 : i_wr_subkey;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOADING: if (&bitmap_q) state_d = READY;
      READY:   if (seq_ok) state_d = STREAM;
      STREAM:  if (hs && last) state_d = READY;
      ZERO:    if (zidx_q == LAST_IDX) state_d = IDLE;
      default: ;
    endcase
    if (load) state_d = LOADING;
    if (zero_go) state_d = ZERO;
  end
  always_comb begin
    bitmap_d = (load || zero_go || in_zero) ? '0
             : wr_ok ? bitmap_q | (NUM_SUBKEYS'(1) << i_wr_addr) : bitmap_q;
    err_d = load ? 1'b0 : err_q | wr_err | seq_err;
    idx_d = seq_ok ? rd_addr : (hs && !last) ? step : idx_q;
    dec_d = seq_ok ? i_seq_decrypt : dec_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      bitmap_q <= '0;
      err_q <= 1'b0;
      idx_q <= '0;
      dec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bitmap_q <= bitmap_d;
      err_q <= err_d;
      idx_q <= idx_d;
      dec_q <= dec_d;
    end
  end
  subkey_ram u_ram (
    .i_clk   (i_clk),
    .i_we    (we),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_re    (re),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );
  assign o_sk_valid = state_q == STREAM;
  assign o_sk_data = o_sk_valid ? rd_data : '0;
  assign o_sk_index = o_sk_valid ? idx_q : '0;
  assign o_sk_last = o_sk_valid && last;
  assign o_keys_ready = state_q == READY || state_q == STREAM;
  assign o_err = err_q;
endmodule

// File: tb/tb_serpent_subkey_store.sv
// tb_serpent_subkey_store: randomized load/replay checks against an array model of the stored subkeys
module tb_serpent_subkey_store;
  import serpent_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, load_begin = 1'b0, wr_valid = 1'b0, seq_start = 1'b0, seq_decrypt = 1'b0, ready = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [SK_W-1:0] wr_subkey = '0;
  logic sk_valid, sk_last, keys_ready, err;
  logic [SK_W-1:0] sk_data;
  logic [ADDR_W-1:0] sk_index;
`ifdef SUBKEY_STORE_ZEROIZE_EN
  logic zeroize = 1'b0, zbusy;
`endif
  int vectors = 0, miscompares = 0;
  logic [SK_W-1:0] ref_k [NUM_SUBKEYS];

  serpent_subkey_store dut (
    .i_clk(clk), .i_rst(rst), .i_load_begin(load_begin), .i_wr_valid(wr_valid),
    .i_wr_addr(wr_addr), .i_wr_subkey(wr_subkey), .i_seq_start(seq_start),
    .i_seq_decrypt(seq_decrypt), .o_sk_valid(sk_valid), .i_sk_ready(ready),
    .o_sk_data(sk_data), .o_sk_index(sk_index), .o_sk_last(sk_last),
    .o_keys_ready(keys_ready),
`ifdef SUBKEY_STORE_ZEROIZE_EN
    .i_zeroize(zeroize), .o_zeroize_busy(zbusy),
`endif
    .o_err(err)
  );

  task automatic chk(input string tag, input logic [SK_W-1:0] got, input logic [SK_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load;
    load_begin = 1'b1;
    tick;
    load_begin = 1'b0;
  endtask

  task automatic wr(input int a, input logic [SK_W-1:0] d);
    wr_valid = 1'b1;
    wr_addr = 6'(a);
    wr_subkey = d;
    tick;
    wr_valid = 1'b0;
    if (a <= 32) ref_k[a] = d;
  endtask

  task automatic full_load(input bit rev);
    pulse_load;
    for (int k = 0; k < NUM_SUBKEYS; k++)
      wr(rev ? 32 - k : k, {$urandom, $urandom, $urandom, $urandom});
    tick;
    chk("load_keys_ready", 128'(keys_ready), 128'(1));
  endtask

  task automatic replay(input bit dec, input int mode, input int abort_at);
    int exp_idx, beats;
    exp_idx = dec ? 32 : 0;
    beats = 0;
    seq_decrypt = dec;
    seq_start = 1'b1;
    tick;
    seq_start = 1'b0;
    chk("first_valid", 128'(sk_valid), 128'(1));
    for (int cyc = 0; cyc < 400 && beats < NUM_SUBKEYS; cyc++) begin
      ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      if (!sk_valid) begin
        chk("valid_gap", 128'(sk_valid), 128'(1));
        break;
      end
      chk("index", 128'(sk_index), 128'(exp_idx));
      chk("data", sk_data, ref_k[exp_idx]);
      chk("last", 128'(sk_last), 128'(exp_idx == (dec ? 0 : 32)));
      if (exp_idx == abort_at) begin
        load_begin = 1'b1;
        tick;
        load_begin = 1'b0;
        ready = 1'b0;
        chk("abort_valid", 128'(sk_valid), 128'(0));
        chk("abort_keys_ready", 128'(keys_ready), 128'(0));
        return;
      end
      tick;
      if (ready) begin
        beats++;
        exp_idx += dec ? -1 : 1;
      end
    end
    ready = 1'b0;
    chk("beats", 128'(beats), 128'(NUM_SUBKEYS));
    chk("end_valid", 128'(sk_valid), 128'(0));
    chk("end_keys_ready", 128'(keys_ready), 128'(1));
  endtask

  initial begin
    logic [31:0] w;
    repeat (2) tick;
    rst = 1'b0;
    chk("rst_valid", 128'(sk_valid), 128'(0));
    chk("rst_data", sk_data, 128'(0));
    chk("rst_index", 128'(sk_index), 128'(0));
    chk("rst_last", 128'(sk_last), 128'(0));
    chk("rst_keys_ready", 128'(keys_ready), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    pulse_load;
    for (int i = 0; i < NUM_SUBKEYS; i++) begin
      w = 32'hA5A50000 + i;
      wr(i, {4{w}});
    end
    chk("keys_ready_early", 128'(keys_ready), 128'(0));
    tick;
    chk("keys_ready", 128'(keys_ready), 128'(1));
    chk("load_err", 128'(err), 128'(0));
    replay(1'b0, 0, -1);
    replay(1'b1, 1, -1);
    replay(1'b0, 2, -1);
    wr_valid = 1'b1;
    wr_addr = '0;
    wr_subkey = '1;
    tick;
    wr_valid = 1'b0;
    chk("wr_ready_err", 128'(err), 128'(1));
    replay(1'b0, 2, -1);
    load_begin = 1'b1;
    wr_valid = 1'b1;
    seq_start = 1'b1;
    tick;
    load_begin = 1'b1;
    tick;
    load_begin = 1'b0;
    wr_valid = 1'b0;
    seq_start = 1'b0;
    chk("load_clears_err", 128'(err), 128'(0));
    chk("reload_keys_ready", 128'(keys_ready), 128'(0));
    pulse_load;
    for (int k = 32; k >= 0; k--) begin
      wr(k, {$urandom, $urandom, $urandom, $urandom});
      if (k == 16) wr(40 + $urandom_range(0, 23), '1);
    end
    chk("bad_addr_err", 128'(err), 128'(1));
    tick;
    chk("ooo_keys_ready", 128'(keys_ready), 128'(1));
    replay(1'b1, 2, -1);
    full_load(1'b0);
    chk("clean_load_err", 128'(err), 128'(0));
    replay(1'b0, 1, -1);
    seq_start = 1'b1;
    tick;
    seq_start = 1'b1;
    ready = 1'b0;
    tick;
    seq_start = 1'b0;
    chk("seq_in_stream_err", 128'(err), 128'(1));
    full_load(1'b1);
    replay(1'b0, 0, 10);
    seq_start = 1'b1;
    tick;
    seq_start = 1'b0;
    chk("seq_after_abort_err", 128'(err), 128'(1));
`ifdef SUBKEY_STORE_ZEROIZE_EN
    begin
      int n;
      full_load(1'b0);
      zeroize = 1'b1;
      tick;
      zeroize = 1'b0;
      n = 0;
      while (zbusy && n < 100) begin
        n++;
        tick;
      end
      chk("zero_busy_cycles", 128'(n), 128'(NUM_SUBKEYS));
      chk("zero_keys_ready", 128'(keys_ready), 128'(0));
      pulse_load;
      for (int i = 0; i < 32; i++) wr(i, {$urandom, $urandom, $urandom, $urandom});
      tick;
      chk("partial_keys_ready", 128'(keys_ready), 128'(0));
      chk("zero_peek", dut.u_ram.mem_q[32], 128'(0));
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
